// File: rtl/seg_pkg.sv
// seg_pkg: shared segment patterns, digit code type and BCD decode function
package seg_pkg;
  typedef logic [3:0] digit_t;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF = 7'h00;
  function automatic logic [6:0] seg_decode(digit_t d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: BCD code to active-high 7-segment pattern, err for codes 10..15
module seg_decoder import seg_pkg::*; (
  input  digit_t     code_i,
  output logic [6:0] seg_o,
  output logic       err_o
);
  assign seg_o = seg_decode(code_i);
  assign err_o = code_i > 4'd9;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans N BCD digits through one decoder; valid/ready load into a pending buffer swapped in at frame wrap
module seg_scan_driver import seg_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    bcd_err
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
  localparam logic POL = ACTIVE_LOW != 0;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_q, act_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0] adp_q, adp_d, pdp_q, pdp_d, en_d, en_q;
  logic pfull_q, pfull_d, ready_q, frame_q, err_q, dp_q;
  logic [6:0] seg_q, dec_seg;
  digit_t code;
  logic dec_err, blank, wrap, take;
  seg_decoder u_dec (.code_i(code), .seg_o(dec_seg), .err_o(dec_err));
  always_comb begin
    wrap = idx_q == IMAX && cnt_q == CMAX;
    take = load_valid && !pfull_q;
    cnt_d = cnt_q == CMAX ? '0 : cnt_q + 1'b1;
    idx_d = cnt_q != CMAX ? idx_q : idx_q == IMAX ? '0 : idx_q + 1'b1;
    act_d = wrap && pfull_q ? pend_q : act_q;
    adp_d = wrap && pfull_q ? pdp_q : adp_q;
    pend_d = take ? load_data : pend_q;
    pdp_d = take ? load_dp : pdp_q;
    // a load landing on the wrap edge is only captured; it swaps in at the next wrap
    pfull_d = pfull_q ? !wrap : take;
    code = act_q[{idx_q, 2'b00} +: 4];
    // blank when this digit and all higher digits are zero, never digit 0
    blank = BLANK_LEADING != 0 && idx_q != '0 && (act_q >> {idx_q, 2'b00}) == '0;
    en_d = NUM_DIGITS'(1) << idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      act_q <= '0;
      adp_q <= '0;
      pend_q <= '0;
      pdp_q <= '0;
      pfull_q <= 1'b0;
      ready_q <= 1'b1;
      frame_q <= 1'b0;
      err_q <= 1'b0;
      seg_q <= {7{POL}};
      dp_q <= POL;
      en_q <= {NUM_DIGITS{POL}};
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      act_q <= act_d;
      adp_q <= adp_d;
      pend_q <= pend_d;
      pdp_q <= pdp_d;
      pfull_q <= pfull_d;
      ready_q <= !pfull_d;
      frame_q <= wrap;
      err_q <= dec_err;
      seg_q <= (blank ? SEG_OFF : dec_seg) ^ {7{POL}};
      dp_q <= adp_q[idx_q] ^ POL;
      en_q <= en_d ^ {NUM_DIGITS{POL}};
    end
  end
  assign load_ready = ready_q;
  assign seg_out = seg_q;
  assign dp_out = dp_q;
  assign digit_en = en_q;
  assign frame_done = frame_q;
  assign bcd_err = err_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed scenario bench for seg_scan_driver with 4 digits, 4 cycles per digit
module tb_seg_scan_driver;
  logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, load_ready;
  logic [15:0] load_data = '0;
  logic [3:0] load_dp = '0, digit_en;
  logic [6:0] seg_out;
  logic dp_out, frame_done, bcd_err;
  int total = 0, bad = 0;
  logic [6:0] seg_a [16];
  logic [3:0] en_a [16];
  logic dp_a [16], err_a [16], fd_a [16], rdy_a [16];
  always #5 clk = ~clk;
  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .seg_out(seg_out), .dp_out(dp_out),
    .digit_en(digit_en), .frame_done(frame_done), .bcd_err(bcd_err)
  );
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic capture;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      seg_a[i] = seg_out;
      en_a[i] = digit_en;
      dp_a[i] = dp_out;
      err_a[i] = bcd_err;
      fd_a[i] = frame_done;
      rdy_a[i] = load_ready;
    end
  endtask
  task automatic offer(input logic [15:0] d, input logic [3:0] p);
    int n = 0;
    load_data = d;
    load_dp = p;
    load_valid = 1'b1;
    while (load_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL offer_timeout: load_ready=%b want 1", load_ready);
    end
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask
  task automatic wait_swap(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (load_ready !== 1'b1 && n < 40);
    total += 2;
    if (n >= 40) begin
      bad++;
      $display("FAIL %s swap_timeout: load_ready=%b want 1", tag, load_ready);
    end
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL %s swap_frame_done: got %b want 1", tag, frame_done);
    end
  endtask
  task automatic test_reset;
    logic [3:0][6:0] es;
    logic [3:0] ee;
    es = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    repeat (3) @(negedge clk);
    total += 6;
    if (seg_out !== 7'h7F) begin bad++; $display("FAIL rst_seg: got %h want 7f", seg_out); end
    if (digit_en !== 4'hF) begin bad++; $display("FAIL rst_en: got %h want f", digit_en); end
    if (dp_out !== 1'b1) begin bad++; $display("FAIL rst_dp: got %b want 1", dp_out); end
    if (load_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", load_ready); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %b want 0", frame_done); end
    if (bcd_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bcd_err); end
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      capture;
      for (int i = 0; i < 16; i++) begin
        ee = ~(4'b0001 << (i / 4));
        total += 5;
        if (seg_a[i] !== es[i/4]) begin bad++; $display("FAIL t1_seg f%0d slot%0d: got %h want %h", f, i, seg_a[i], es[i/4]); end
        if (en_a[i] !== ee) begin bad++; $display("FAIL t1_en f%0d slot%0d: got %h want %h", f, i, en_a[i], ee); end
        if (dp_a[i] !== 1'b1) begin bad++; $display("FAIL t1_dp f%0d slot%0d: got %b want 1", f, i, dp_a[i]); end
        if (err_a[i] !== 1'b0) begin bad++; $display("FAIL t1_err f%0d slot%0d: got %b want 0", f, i, err_a[i]); end
        if (fd_a[i] !== (i == 15)) begin bad++; $display("FAIL t1_fd f%0d slot%0d: got %b want %b", f, i, fd_a[i], i == 15); end
      end
    end
  endtask
  task automatic test_value(input string tag, input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0][6:0] es, input logic [3:0] edp, input logic [3:0] eerr);
    logic [3:0] ee;
    offer(d, p);
    wait_swap(tag);
    capture;
    for (int i = 0; i < 16; i++) begin
      ee = ~(4'b0001 << (i / 4));
      total += 5;
      if (seg_a[i] !== es[i/4]) begin bad++; $display("FAIL %s_seg slot%0d: got %h want %h", tag, i, seg_a[i], es[i/4]); end
      if (en_a[i] !== ee) begin bad++; $display("FAIL %s_en slot%0d: got %h want %h", tag, i, en_a[i], ee); end
      if (dp_a[i] !== edp[i/4]) begin bad++; $display("FAIL %s_dp slot%0d: got %b want %b", tag, i, dp_a[i], edp[i/4]); end
      if (err_a[i] !== eerr[i/4]) begin bad++; $display("FAIL %s_err slot%0d: got %b want %b", tag, i, err_a[i], eerr[i/4]); end
      if (fd_a[i] !== (i == 15)) begin bad++; $display("FAIL %s_fd slot%0d: got %b want %b", tag, i, fd_a[i], i == 15); end
    end
  endtask
  task automatic test_back_to_back;
    logic [3:0][6:0] es;
    offer(16'h1111, 4'h0);
    load_data = 16'h2222;
    load_valid = 1'b1;
    wait_swap("t5");
    @(posedge clk);
    #1 load_valid = 1'b0;
    for (int f = 0; f < 2; f++) begin
      es = f == 0 ? {4{7'h79}} : {4{7'h24}};
      capture;
      for (int i = 0; i < 16; i++) begin
        total += 3;
        if (seg_a[i] !== es[i/4]) begin bad++; $display("FAIL t5_seg f%0d slot%0d: got %h want %h", f, i, seg_a[i], es[i/4]); end
        if (fd_a[i] !== (i == 15)) begin bad++; $display("FAIL t5_fd f%0d slot%0d: got %b want %b", f, i, fd_a[i], i == 15); end
        if (f == 0 && rdy_a[i] !== (i == 15)) begin bad++; $display("FAIL t5_ready f%0d slot%0d: got %b want %b", f, i, rdy_a[i], i == 15); end
        if (f == 1 && rdy_a[i] !== 1'b1) begin bad++; $display("FAIL t5_ready f%0d slot%0d: got %b want 1", f, i, rdy_a[i]); end
      end
    end
  endtask
  task automatic test_reset_mid_frame;
    logic [3:0][6:0] es;
    es = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    offer(16'h5555, 4'h0);
    repeat (3) @(negedge clk);
    total++;
    if (load_ready !== 1'b0) begin bad++; $display("FAIL t6_pending_ready: got %b want 0", load_ready); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total += 5;
    if (seg_out !== 7'h7F) begin bad++; $display("FAIL t6_rst_seg: got %h want 7f", seg_out); end
    if (digit_en !== 4'hF) begin bad++; $display("FAIL t6_rst_en: got %h want f", digit_en); end
    if (dp_out !== 1'b1) begin bad++; $display("FAIL t6_rst_dp: got %b want 1", dp_out); end
    if (load_ready !== 1'b1) begin bad++; $display("FAIL t6_rst_ready: got %b want 1", load_ready); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL t6_rst_fd: got %b want 0", frame_done); end
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      capture;
      for (int i = 0; i < 16; i++) begin
        total += 4;
        if (seg_a[i] !== es[i/4]) begin bad++; $display("FAIL t6_seg f%0d slot%0d: got %h want %h", f, i, seg_a[i], es[i/4]); end
        if (en_a[i] !== ~(4'b0001 << (i / 4))) begin bad++; $display("FAIL t6_en f%0d slot%0d: got %h", f, i, en_a[i]); end
        if (rdy_a[i] !== 1'b1) begin bad++; $display("FAIL t6_ready f%0d slot%0d: got %b want 1", f, i, rdy_a[i]); end
        if (fd_a[i] !== (i == 15)) begin bad++; $display("FAIL t6_fd f%0d slot%0d: got %b want %b", f, i, fd_a[i], i == 15); end
      end
    end
  endtask
  initial begin
    test_reset;
    test_value("t2", 16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b0000);
    test_value("t3", 16'h0007, 4'b0100, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1011, 4'b0000);
    test_value("t4", 16'h000A, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h3F}, 4'b1111, 4'b0001);
    test_back_to_back;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
